// File: rtl/bcd_to_bin_seq_if.sv
// Start/busy/done handshake bundle for the BCD-to-binary converter.
// The master drives requests; the slave (the converter) returns status and result.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [BIN_W-1:0]      bin_out;

  modport master (output start, bcd_in, input busy, done, err, bin_out);
  modport slave  (input start, bcd_in, output busy, done, err, bin_out);
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one bit per clock.
// Invalid digits (>9) short-circuit straight to DONE with err set.
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic             clk,
    input  logic             rst,
    bcd_to_bin_seq_if.slave  bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [SR_W-1:0]   sr, sr_shift, sr_fix;
    logic [CNT_W-1:0]  cnt;
    logic [DIGITS-1:0] dig_bad;
    logic              in_bad, accept, last;
    logic              err_q;
    logic [BIN_W-1:0]  bin_q;

    assign sr_shift = {1'b0, sr[SR_W-1:1]};
    assign sr_fix[BIN_W-1:0] = sr_shift[BIN_W-1:0];

    // Per-digit input validation and post-shift correction, all digits in parallel.
    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        logic [3:0] dg;
        assign dig_bad[d] = bus.bcd_in[4*d +: 4] > 4'd9;
        assign dg         = sr_shift[BIN_W + 4*d +: 4];
        assign sr_fix[BIN_W + 4*d +: 4] = (dg >= 4'd8) ? dg - 4'd3 : dg;
    end

    assign in_bad = |dig_bad;
    assign accept = bus.start && (state == IDLE || state == DONE);
    assign last   = (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = in_bad ? DONE : SHIFT;
            SHIFT:   if (last)      state_nxt = DONE;
            DONE:    state_nxt = bus.start ? (in_bad ? DONE : SHIFT) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr    <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
            bin_q <= '0;
        end else if (accept) begin
            sr    <= in_bad ? '0 : {bus.bcd_in, {BIN_W{1'b0}}};
            cnt   <= in_bad ? '0 : CNT_W'(BIN_W);
            err_q <= in_bad;
            bin_q <= '0;
        end else if (state == SHIFT) begin
            sr  <= sr_fix;
            cnt <= cnt - CNT_W'(1);
            if (last) bin_q <= sr_fix[BIN_W-1:0];
        end
    end

    assign bus.busy    = (state == SHIFT);
    assign bus.done    = (state == DONE);
    assign bus.err     = err_q;
    assign bus.bin_out = bin_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: directed scenarios plus a full valid sweep
// and random (possibly invalid) inputs against an arithmetic reference model.
module tb_bcd_to_bin_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    bcd_to_bin_seq_if #(.DIGITS(3), .BIN_W(10)) bus ();

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_model(input logic [11:0] b, output int v, output logic e);
        int dg;
        v = 0;
        e = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            dg = int'((b >> (4*i)) & 12'hF);
            if (dg > 9) e = 1'b1;
            v = v * 10 + dg;
        end
        if (e) v = 0;
    endfunction

    // Issue one start and run until done (bounded); returns cycles from k to done.
    task automatic do_conv(input logic [11:0] b, output int lat, output int busy_cnt,
                           output logic first_busy);
        bus.start  = 1'b1;
        bus.bcd_in = b;
        tick();
        bus.start  = 1'b0;
        bus.bcd_in = $urandom_range(4095, 0);
        lat        = 1;
        busy_cnt   = 0;
        first_busy = bus.busy;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.bcd_in = '0;
        tick(); tick();
        n_checks += 4;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", bus.done); end
        if (bus.err !== 1'b0)  begin n_fail++; $display("FAIL reset_err: got %b exp 0", bus.err); end
        if (bus.bin_out !== 10'd0) begin n_fail++; $display("FAIL reset_bin: got %0d exp 0", bus.bin_out); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero();
        int lat, bc; logic fb;
        do_conv(12'h000, lat, bc, fb);
        n_checks += 5;
        if (lat != 11) begin n_fail++; $display("FAIL zero_latency: got %0d exp 11", lat); end
        if (bc != 10) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d exp 10", bc); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_at_done: got %b exp 0", bus.busy); end
        if (bus.bin_out !== 10'd0) begin n_fail++; $display("FAIL zero_bin: got %0d exp 0", bus.bin_out); end
        if (bus.err !== 1'b0) begin n_fail++; $display("FAIL zero_err: got %b exp 0", bus.err); end
        tick();
    endtask

    task automatic test_known();
        int lat, bc; logic fb;
        do_conv(12'h999, lat, bc, fb);
        n_checks += 3;
        if (bus.bin_out !== 10'h3E7) begin n_fail++; $display("FAIL known_999: got %0d exp 999", bus.bin_out); end
        if (bus.err !== 1'b0) begin n_fail++; $display("FAIL known_999_err: got %b exp 0", bus.err); end
        if (lat != 11) begin n_fail++; $display("FAIL known_999_latency: got %0d exp 11", lat); end
        tick();
        n_checks += 2;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got %b exp 0", bus.done); end
        if (bus.bin_out !== 10'd999) begin n_fail++; $display("FAIL bin_hold: got %0d exp 999", bus.bin_out); end
        do_conv(12'h159, lat, bc, fb);
        n_checks++;
        if (bus.bin_out !== 10'd159) begin n_fail++; $display("FAIL known_159: got %0d exp 159", bus.bin_out); end
        tick();
    endtask

    task automatic test_sweep();
        int lat, bc; logic fb;
        logic [11:0] b;
        for (int i = 0; i < 1000; i++) begin
            b = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
            do_conv(b, lat, bc, fb);
            n_checks += 2;
            if (bus.bin_out !== 10'(i) || bus.err !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_%03h: got %0d err %b exp %0d err 0", b, bus.bin_out, bus.err, i);
            end
            if (lat != 11) begin n_fail++; $display("FAIL sweep_latency_%03h: got %0d exp 11", b, lat); end
            tick();
        end
    endtask

    task automatic test_random();
        int lat, bc, ev; logic fb, ee;
        logic [11:0] b;
        for (int i = 0; i < 300; i++) begin
            b = 12'($urandom_range(4095, 0));
            ref_model(b, ev, ee);
            do_conv(b, lat, bc, fb);
            n_checks += 3;
            if (bus.bin_out !== 10'(ev)) begin n_fail++; $display("FAIL rand_bin_%03h: got %0d exp %0d", b, bus.bin_out, ev); end
            if (bus.err !== ee) begin n_fail++; $display("FAIL rand_err_%03h: got %b exp %b", b, bus.err, ee); end
            if (lat != (ee ? 1 : 11)) begin n_fail++; $display("FAIL rand_latency_%03h: got %0d exp %0d", b, lat, ee ? 1 : 11); end
            tick();
        end
    endtask

    task automatic test_invalid();
        int lat, bc; logic fb;
        logic [11:0] vec [2];
        vec[0] = 12'h1A3;
        vec[1] = 12'hF00;
        for (int i = 0; i < 2; i++) begin
            do_conv(vec[i], lat, bc, fb);
            n_checks += 4;
            if (lat != 1) begin n_fail++; $display("FAIL inv_latency_%03h: got %0d exp 1", vec[i], lat); end
            if (bus.err !== 1'b1) begin n_fail++; $display("FAIL inv_err_%03h: got %b exp 1", vec[i], bus.err); end
            if (bus.bin_out !== 10'd0) begin n_fail++; $display("FAIL inv_bin_%03h: got %0d exp 0", vec[i], bus.bin_out); end
            if (fb !== 1'b0 || bc != 0) begin n_fail++; $display("FAIL inv_busy_%03h: got %0d exp 0", vec[i], bc + int'(fb)); end
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int ndone, first_cyc;
        logic [9:0] res;
        bus.start  = 1'b1;
        bus.bcd_in = 12'h500;
        tick();
        bus.start  = 1'b0;
        ndone = 0;
        first_cyc = 0;
        res = '0;
        for (int c = 1; c <= 20; c++) begin
            if (bus.done) begin
                ndone++;
                if (first_cyc == 0) begin first_cyc = c; res = bus.bin_out; end
            end
            bus.start  = (c == 4);
            bus.bcd_in = (c == 4) ? 12'h123 : 12'h000;
            tick();
        end
        bus.start = 1'b0;
        n_checks += 3;
        if (ndone != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d exp 1", ndone); end
        if (first_cyc != 11) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d exp 11", first_cyc); end
        if (res !== 10'd500) begin n_fail++; $display("FAIL ignore_bin: got %0d exp 500", res); end
    endtask

    task automatic test_reset_mid();
        int ndone;
        bus.start  = 1'b1;
        bus.bcd_in = 12'h777;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks += 4;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b exp 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b exp 0", bus.done); end
        if (bus.err !== 1'b0)  begin n_fail++; $display("FAIL rstmid_err: got %b exp 0", bus.err); end
        if (bus.bin_out !== 10'd0) begin n_fail++; $display("FAIL rstmid_bin: got %0d exp 0", bus.bin_out); end
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.done) ndone++;
            tick();
        end
        n_checks++;
        if (ndone != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d exp 0", ndone); end
    endtask

    task automatic test_back_to_back();
        int lat, bc; logic fb;
        do_conv(12'h042, lat, bc, fb);
        n_checks++;
        if (bus.bin_out !== 10'd42 || !bus.done) begin n_fail++; $display("FAIL b2b_first: got %0d exp 42", bus.bin_out); end
        do_conv(12'h318, lat, bc, fb);
        n_checks += 3;
        if (fb !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_rise: got %b exp 1", fb); end
        if (lat != 11) begin n_fail++; $display("FAIL b2b_latency: got %0d exp 11", lat); end
        if (bus.bin_out !== 10'd318) begin n_fail++; $display("FAIL b2b_second: got %0d exp 318", bus.bin_out); end
        tick();
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        test_reset();
        test_zero();
        test_known();
        test_invalid();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
